ex_mem_reg: RTL and testbench

- Pipeline register between the execute stage and the memory stage of the 5-stage MIPS core.
- Captures EX results: GPR write, HI/LO write, load/store address and store data, aluop.
- Honours the global stall vector and flush; inserts bubbles into MEM when EX stalls but MEM proceeds.
- Feeds the multi-cycle MADD/MADDU/MSUB/MSUBU accumulator state (partial product, cycle count) back to EX while EX is stalled.

---
 rtl/ex_mem_reg_if.sv | 52 +++++
 rtl/ex_mem_reg.sv | 94 +++++++++
 tb/tb_ex_mem_reg.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_reg_if.sv
// EX->MEM pipeline bus: EX results, stall/flush control, and the multi-cycle accumulator loop back to EX.
interface ex_mem_reg_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2
);
    logic [5:0]          stall;
    logic                flush;

    logic                ex_wreg;
    logic [ADDR_W-1:0]   ex_waddr;
    logic [DATA_W-1:0]   ex_wdata;
    logic                ex_whilo;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [DATA_W-1:0]   ex_mem_addr;
    logic [DATA_W-1:0]   ex_reg2;
    logic [2*DATA_W-1:0] hilo_i;
    logic [CNT_W-1:0]    cnt_i;

    logic                mem_wreg;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_whilo;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic [ALUOP_W-1:0]  mem_aluop;
    logic [DATA_W-1:0]   mem_mem_addr;
    logic [DATA_W-1:0]   mem_reg2;
    logic [2*DATA_W-1:0] hilo_o;
    logic [CNT_W-1:0]    cnt_o;

    // EX side drives results and control
    modport master (
        output stall, flush,
        output ex_wreg, ex_waddr, ex_wdata, ex_whilo, ex_hi, ex_lo,
        output ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
        input  mem_wreg, mem_waddr, mem_wdata, mem_whilo, mem_hi, mem_lo,
        input  mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
    );

    // The pipeline register
    modport slave (
        input  stall, flush,
        input  ex_wreg, ex_waddr, ex_wdata, ex_whilo, ex_hi, ex_lo,
        input  ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
        output mem_wreg, mem_waddr, mem_wdata, mem_whilo, mem_hi, mem_lo,
        output mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register, 1-cycle latency, all outputs registered.
// EX stall with MEM running inserts a bubble; both stalled holds MEM; accumulator state loops back while EX stalls.
module ex_mem_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_reg_if.slave   bus
);
    typedef struct packed {
        logic               wreg;
        logic [ADDR_W-1:0]  waddr;
        logic [DATA_W-1:0]  wdata;
        logic               whilo;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  mem_addr;
        logic [DATA_W-1:0]  reg2;
    } mem_t;

    mem_t                mem_q, mem_d, ex_in;
    logic [2*DATA_W-1:0] hilo_q, hilo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic ex_stall;
    logic mem_stall;
    logic unused_stall_bits;

    assign ex_stall          = bus.stall[3];
    assign mem_stall         = bus.stall[4];
    assign unused_stall_bits = ^{bus.stall[5], bus.stall[2:0]};

    assign ex_in = '{
        wreg:     bus.ex_wreg,
        waddr:    bus.ex_waddr,
        wdata:    bus.ex_wdata,
        whilo:    bus.ex_whilo,
        hi:       bus.ex_hi,
        lo:       bus.ex_lo,
        aluop:    bus.ex_aluop,
        mem_addr: bus.ex_mem_addr,
        reg2:     bus.ex_reg2
    };

    always_comb begin
        mem_d  = mem_q;
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
        if (bus.flush) begin
            mem_d  = '0;
            hilo_d = '0;
            cnt_d  = '0;
        end else if (!ex_stall) begin
            // mem_stall without ex_stall cannot happen; treating it as advance is the safe choice
            mem_d  = ex_in;
            hilo_d = '0;
            cnt_d  = '0;
        end else begin
            if (!mem_stall) begin
                mem_d = '0;
            end
            hilo_d = bus.hilo_i;
            cnt_d  = bus.cnt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            hilo_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            hilo_q <= hilo_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.mem_wreg     = mem_q.wreg;
    assign bus.mem_waddr    = mem_q.waddr;
    assign bus.mem_wdata    = mem_q.wdata;
    assign bus.mem_whilo    = mem_q.whilo;
    assign bus.mem_hi       = mem_q.hi;
    assign bus.mem_lo       = mem_q.lo;
    assign bus.mem_aluop    = mem_q.aluop;
    assign bus.mem_mem_addr = mem_q.mem_addr;
    assign bus.mem_reg2     = mem_q.reg2;
    assign bus.hilo_o       = hilo_q;
    assign bus.cnt_o        = cnt_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg with hand-computed expectations.
module tb_ex_mem_reg;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    ex_mem_reg_if #(.DATA_W(32), .ADDR_W(5), .ALUOP_W(8), .CNT_W(2)) bus ();

    ex_mem_reg #(.DATA_W(32), .ADDR_W(5), .ALUOP_W(8), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle before sampling
    task automatic step();
        n_vec++;
        assert (!(bus.stall[4] && !bus.stall[3]))
        else begin
            n_err++;
            $error("FAIL stall_vec: observed %b expected a stall prefix", bus.stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ex_all(input logic [31:0] v);
        bus.ex_wreg     = v[0];
        bus.ex_waddr    = v[4:0];
        bus.ex_wdata    = v;
        bus.ex_whilo    = v[0];
        bus.ex_hi       = v;
        bus.ex_lo       = v;
        bus.ex_aluop    = v[7:0];
        bus.ex_mem_addr = v;
        bus.ex_reg2     = v;
        bus.hilo_i      = {v, v};
        bus.cnt_i       = v[1:0];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wreg"},  {63'd0, bus.mem_wreg},   64'd0);
        check({tag, ".waddr"}, {59'd0, bus.mem_waddr},  64'd0);
        check({tag, ".wdata"}, {32'd0, bus.mem_wdata},  64'd0);
        check({tag, ".whilo"}, {63'd0, bus.mem_whilo},  64'd0);
        check({tag, ".hi"},    {32'd0, bus.mem_hi},     64'd0);
        check({tag, ".lo"},    {32'd0, bus.mem_lo},     64'd0);
        check({tag, ".aluop"}, {56'd0, bus.mem_aluop},  64'd0);
        check({tag, ".addr"},  {32'd0, bus.mem_mem_addr}, 64'd0);
        check({tag, ".reg2"},  {32'd0, bus.mem_reg2},   64'd0);
        check({tag, ".hilo"},  bus.hilo_o,              64'd0);
        check({tag, ".cnt"},   {62'd0, bus.cnt_o},      64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // reset with every EX input driven high
        rst       = 1'b1;
        bus.stall = 6'b0;
        bus.flush = 1'b0;
        ex_all(32'hFFFF_FFFF);
        step();
        step();
        check_all_zero("reset");

        // first transaction after reset
        rst = 1'b0;
        ex_all(32'h0);
        bus.ex_wreg  = 1'b1;
        bus.ex_waddr = 5'd5;
        bus.ex_wdata = 32'h1234;
        step();
        check("first.wreg",  {63'd0, bus.mem_wreg},  64'd1);
        check("first.waddr", {59'd0, bus.mem_waddr}, 64'd5);
        check("first.wdata", {32'd0, bus.mem_wdata}, 64'h1234);

        // advance stream: accumulator inputs must not leak through
        bus.hilo_i = 64'h55;
        bus.cnt_i  = 2'd2;
        for (int i = 1; i <= 3; i++) begin
            bus.ex_wdata = 32'(i);
            step();
            check("adv.wdata", {32'd0, bus.mem_wdata}, 64'(i));
            check("adv.hilo",  bus.hilo_o,             64'd0);
            check("adv.cnt",   {62'd0, bus.cnt_o},     64'd0);
        end

        // bubble: EX stalled, MEM running
        bus.stall    = 6'b001111;
        bus.ex_wreg  = 1'b1;
        bus.ex_whilo = 1'b1;
        bus.ex_aluop = 8'h21;
        bus.ex_hi    = 32'h11;
        bus.ex_lo    = 32'h22;
        bus.ex_wdata = 32'h77;
        bus.hilo_i   = 64'h00000001_80000000;
        bus.cnt_i    = 2'd1;
        step();
        check("bub.wreg",  {63'd0, bus.mem_wreg},  64'd0);
        check("bub.whilo", {63'd0, bus.mem_whilo}, 64'd0);
        check("bub.aluop", {56'd0, bus.mem_aluop}, 64'd0);
        check("bub.wdata", {32'd0, bus.mem_wdata}, 64'd0);
        check("bub.hilo",  bus.hilo_o,             64'h00000001_80000000);
        check("bub.cnt",   {62'd0, bus.cnt_o},     64'd1);

        // EX completes the op and advances
        bus.stall = 6'b0;
        step();
        check("done.hilo",  bus.hilo_o,             64'd0);
        check("done.cnt",   {62'd0, bus.cnt_o},     64'd0);
        check("done.wreg",  {63'd0, bus.mem_wreg},  64'd1);
        check("done.whilo", {63'd0, bus.mem_whilo}, 64'd1);
        check("done.aluop", {56'd0, bus.mem_aluop}, 64'h21);
        check("done.wdata", {32'd0, bus.mem_wdata}, 64'h77);
        check("done.hi",    {32'd0, bus.mem_hi},    64'h11);
        check("done.lo",    {32'd0, bus.mem_lo},    64'h22);

        // hold: MEM keeps its value, accumulator tracks EX
        bus.ex_wdata = 32'hAAAA;
        step();
        check("hold.load", {32'd0, bus.mem_wdata}, 64'hAAAA);
        bus.stall    = 6'b011111;
        bus.ex_wdata = 32'hBBBB;
        for (int i = 0; i < 3; i++) begin
            bus.hilo_i = 64'h100 + 64'(i);
            bus.cnt_i  = 2'(i);
            step();
            check("hold.wdata", {32'd0, bus.mem_wdata}, 64'hAAAA);
            check("hold.wreg",  {63'd0, bus.mem_wreg},  64'd1);
            check("hold.hilo",  bus.hilo_o,             64'h100 + 64'(i));
            check("hold.cnt",   {62'd0, bus.cnt_o},     64'(i));
        end
        bus.stall = 6'b0;
        step();
        check("hold.rel", {32'd0, bus.mem_wdata}, 64'hBBBB);

        // flush during a bubble
        bus.stall  = 6'b001111;
        bus.hilo_i = 64'hDEAD;
        bus.cnt_i  = 2'd1;
        step();
        check("pre_fl.hilo", bus.hilo_o,         64'hDEAD);
        check("pre_fl.cnt",  {62'd0, bus.cnt_o}, 64'd1);
        bus.flush = 1'b1;
        step();
        check_all_zero("flush_bub");

        // flush beats advance
        bus.stall = 6'b0;
        ex_all(32'h0000_0099);
        step();
        check_all_zero("flush_adv");
        bus.flush = 1'b0;

        // store path
        ex_all(32'h0);
        bus.ex_aluop    = 8'h2B;
        bus.ex_mem_addr = 32'h8000_0010;
        bus.ex_reg2     = 32'hCAFE_BABE;
        step();
        check("st.aluop", {56'd0, bus.mem_aluop},    64'h2B);
        check("st.addr",  {32'd0, bus.mem_mem_addr}, 64'h8000_0010);
        check("st.reg2",  {32'd0, bus.mem_reg2},     64'hCAFE_BABE);

        // stall bits outside EX/MEM do not matter
        bus.stall    = 6'b100111;
        bus.ex_wdata = 32'h5A5A;
        step();
        check("ign.wdata", {32'd0, bus.mem_wdata}, 64'h5A5A);
        check("ign.aluop", {56'd0, bus.mem_aluop}, 64'h2B);

        // reset in the middle of a multi-cycle op
        bus.stall  = 6'b001111;
        bus.hilo_i = 64'h1234_5678_9ABC_DEF0;
        bus.cnt_i  = 2'd1;
        step();
        check("mc.cnt", {62'd0, bus.cnt_o}, 64'd1);
        rst = 1'b1;
        step();
        check_all_zero("rst_mc");
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
